// File: rtl/io_line_config_loader_if.sv
// Bitstream word handshake and committed-configuration bus for the IO line config loader.
interface io_line_config_loader_if #(
  parameter int CONFIG_WIDTH = 288,
  parameter int WORD_WIDTH   = 8
);
  logic                    start;
  logic [WORD_WIDTH-1:0]   word_in;
  logic                    word_valid;
  logic                    word_ready;
  logic [CONFIG_WIDTH-1:0] config_out;
  logic                    busy;
  logic                    done;
  logic                    error;

  modport master (
    output start, word_in, word_valid,
    input  word_ready, config_out, busy, done, error
  );

  modport slave (
    input  start, word_in, word_valid,
    output word_ready, config_out, busy, done, error
  );
endinterface

// File: rtl/io_line_config_loader.sv
// Loads NWORDS bitstream words into a shadow register, verifies an XOR checksum word,
// and only then commits the shadow to config_out so the IO line never sees a partial load.
module io_line_config_loader #(
  parameter int CONFIG_WIDTH = 288,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  io_line_config_loader_if.slave      cfg_bus
);

  localparam int NWORDS = CONFIG_WIDTH / WORD_WIDTH;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t                  state_q,  state_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [WORD_WIDTH-1:0]   csum_q,   csum_d;
  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] config_q, config_d;
  logic                    done_q,   done_d;
  logic                    error_q,  error_d;
  logic                    xfer_s;

  function automatic logic [WORD_WIDTH-1:0] csum_fold(
    input logic [WORD_WIDTH-1:0] acc,
    input logic [WORD_WIDTH-1:0] word
  );
    return acc ^ word;
  endfunction

  assign cfg_bus.word_ready = (state_q != ST_IDLE);
  assign cfg_bus.busy       = (state_q != ST_IDLE);
  assign cfg_bus.config_out = config_q;
  assign cfg_bus.done       = done_q;
  assign cfg_bus.error      = error_q;

  assign xfer_s = cfg_bus.word_valid && (state_q != ST_IDLE);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      csum_q   <= {WORD_WIDTH{1'b0}};
      shadow_q <= {CONFIG_WIDTH{1'b0}};
      config_q <= {CONFIG_WIDTH{1'b0}};
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      config_q <= config_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Next-state and datapath update; start in any state (re)opens a load and wins over a word
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    config_d = config_q;
    done_d   = 1'b0;
    error_d  = error_q;

    if (cfg_bus.start) begin
      state_d = ST_LOAD;
      cnt_d   = {CNT_W{1'b0}};
      csum_d  = {WORD_WIDTH{1'b0}};
      error_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          if (xfer_s) begin
            for (int k = 0; k < NWORDS; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = cfg_bus.word_in;
              end else begin
                shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = shadow_q[k*WORD_WIDTH +: WORD_WIDTH];
              end
            end
            csum_d = csum_fold(csum_q, cfg_bus.word_in);
            if (cnt_q == LAST_IDX) begin
              state_d = ST_CHECK;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_CHECK: begin
          if (xfer_s) begin
            state_d = ST_IDLE;
            if (cfg_bus.word_in == csum_q) begin
              config_d = shadow_q;
              done_d   = 1'b1;
            end else begin
              error_d  = 1'b1;
            end
          end else begin
            state_d = ST_CHECK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_line_config_loader.sv
// Self-checking bench: directed table, named scenarios and randomized loads against a queue-based model.
module tb_io_line_config_loader;

  localparam int CW = 288;
  localparam int WW = 8;
  localparam int NW = CW / WW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  io_line_config_loader_if #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) bus ();

  io_line_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model: an open load is just a queue of received words
  bit          m_active;
  logic [7:0]  m_q[$];
  logic [CW-1:0] m_cfg;
  bit          m_done;
  bit          m_err;

  typedef struct {
    bit         s;
    bit         v;
    logic [7:0] w;
    bit         e_busy;
    bit         e_ready;
    bit         e_done;
  } vec_t;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_q.delete();
    m_cfg = {CW{1'b0}};
    m_done = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit v, input logic [7:0] w);
    logic [7:0] x;
    m_done = 1'b0;
    if (s) begin
      m_active = 1'b1;
      m_q.delete();
      m_err = 1'b0;
    end else if (m_active && v) begin
      if (m_q.size() < NW) begin
        m_q.push_back(w);
      end else begin
        x = 8'h00;
        foreach (m_q[i]) x = x ^ m_q[i];
        if (w == x) begin
          for (int i = 0; i < NW; i++) m_cfg[i*WW +: WW] = m_q[i];
          m_done = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_active = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("busy",       {{(CW-1){1'b0}}, bus.busy},       {{(CW-1){1'b0}}, m_active});
    check("word_ready", {{(CW-1){1'b0}}, bus.word_ready}, {{(CW-1){1'b0}}, m_active});
    check("done",       {{(CW-1){1'b0}}, bus.done},       {{(CW-1){1'b0}}, m_done});
    check("error",      {{(CW-1){1'b0}}, bus.error},      {{(CW-1){1'b0}}, m_err});
    check("config_out", bus.config_out, m_cfg);
  endtask

  task automatic step(input bit s, input bit v, input logic [7:0] w);
    @(negedge clk);
    bus.start = s;
    bus.word_valid = v;
    bus.word_in = w;
    @(posedge clk);
    model_step(s, v, w);
    #1;
    compare_all();
    if (bus.done) done_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.start = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_in = 8'h00;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [CW-1:0] exp32;
  logic [7:0] xs;
  vec_t tbl[6];

  initial begin
    bus.start = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_in = 8'h00;
    model_reset();
    for (int k = 0; k < NW; k++) exp32[k*WW +: WW] = 8'(k + 1);

    // Directed table: idle word ignored, start+word in idle, abort with word, stall
    tbl[0] = '{s:1'b0, v:1'b1, w:8'h77, e_busy:1'b0, e_ready:1'b0, e_done:1'b0};
    tbl[1] = '{s:1'b0, v:1'b1, w:8'h77, e_busy:1'b0, e_ready:1'b0, e_done:1'b0};
    tbl[2] = '{s:1'b1, v:1'b1, w:8'h77, e_busy:1'b1, e_ready:1'b1, e_done:1'b0};
    tbl[3] = '{s:1'b0, v:1'b0, w:8'h12, e_busy:1'b1, e_ready:1'b1, e_done:1'b0};
    tbl[4] = '{s:1'b1, v:1'b1, w:8'hAB, e_busy:1'b1, e_ready:1'b1, e_done:1'b0};
    tbl[5] = '{s:1'b0, v:1'b0, w:8'h00, e_busy:1'b1, e_ready:1'b1, e_done:1'b0};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].w);
      check("tbl_busy",  {{(CW-1){1'b0}}, bus.busy},       {{(CW-1){1'b0}}, tbl[i].e_busy});
      check("tbl_ready", {{(CW-1){1'b0}}, bus.word_ready}, {{(CW-1){1'b0}}, tbl[i].e_ready});
      check("tbl_done",  {{(CW-1){1'b0}}, bus.done},       {{(CW-1){1'b0}}, tbl[i].e_done});
      check("tbl_cfg",   bus.config_out, {CW{1'b0}});
    end
    // Complete the load opened by the table; discarded words would shift the result
    xs = 8'h00;
    for (int k = 0; k < NW; k++) begin
      step(1'b0, 1'b1, 8'(3 * k + 5));
      xs = xs ^ 8'(3 * k + 5);
    end
    step(1'b0, 1'b1, xs);
    check("tbl_load_word0", {{(CW-8){1'b0}}, bus.config_out[7:0]}, {{(CW-8){1'b0}}, 8'h05});

    // Counting load with checksum 0x24
    do_reset();
    done_cnt = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= NW; k++) step(1'b0, 1'b1, 8'(k));
    step(1'b0, 1'b1, 8'h24);
    step(1'b0, 1'b0, 8'h00);
    check("cnt_cfg", bus.config_out, exp32);
    check("cnt_lsb", {{(CW-8){1'b0}}, bus.config_out[7:0]},     {{(CW-8){1'b0}}, 8'h01});
    check("cnt_msb", {{(CW-8){1'b0}}, bus.config_out[287:280]}, {{(CW-8){1'b0}}, 8'h24});
    check("cnt_done_pulses", CW'(done_cnt), CW'(1));

    // Bad checksum leaves config_out untouched and sets error
    done_cnt = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < NW; k++) step(1'b0, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    check("bad_err", {{(CW-1){1'b0}}, bus.error}, {{(CW-1){1'b0}}, 1'b1});
    check("bad_cfg", bus.config_out, exp32);
    check("bad_done_pulses", CW'(done_cnt), CW'(0));

    // Same counting load with word_valid toggling
    done_cnt = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= NW; k++) begin
      step(1'b0, 1'b1, 8'(k));
      step(1'b0, 1'b0, 8'hEE);
    end
    check("tog_err_cleared", {{(CW-1){1'b0}}, bus.error}, {CW{1'b0}});
    step(1'b0, 1'b1, 8'h24);
    check("tog_cfg", bus.config_out, exp32);
    check("tog_done_pulses", CW'(done_cnt), CW'(1));

    // Abort after 10 words, then an all-ones load
    done_cnt = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'hAA);
    for (int k = 0; k < NW; k++) step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("abort_cfg", bus.config_out, {CW{1'b1}});
    check("abort_done_pulses", CW'(done_cnt), CW'(1));

    // Asynchronous reset in the middle of a load
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 8'h33);
    @(negedge clk);
    bus.word_valid = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_cfg",   bus.config_out, {CW{1'b0}});
    check("arst_busy",  {{(CW-1){1'b0}}, bus.busy},       {CW{1'b0}});
    check("arst_ready", {{(CW-1){1'b0}}, bus.word_ready}, {CW{1'b0}});
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h77);

    // Randomized loads with stalls, occasional aborts and corrupted checksums
    for (int r = 0; r < 8; r++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      for (int k = 0; k < NW; k++) begin
        while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 8'($urandom));
        if ($urandom_range(0, 60) == 0) step(1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b1, 8'($urandom));
      end
      for (int g = 0; g < 3 * NW && m_active; g++) begin
        if (m_q.size() == NW) begin
          xs = 8'h00;
          foreach (m_q[i]) xs = xs ^ m_q[i];
          if ($urandom_range(0, 3) == 0) xs = xs ^ 8'(1 << $urandom_range(0, 7));
          step(1'b0, 1'b1, xs);
        end else begin
          step(1'b0, 1'b1, 8'($urandom));
        end
      end
      step(1'b0, 1'b0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
